// File: rtl/alu_uart_sequencer_if.sv
// Byte-stream and ALU signal bundle for alu_uart_sequencer.
// The master drives the received bytes, ALU result and TX done; the slave is the sequencer.
interface alu_uart_sequencer_if #(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = 6
);
  logic [SIZEDATA-1:0] rx_data;
  logic                rx_done;
  logic [SIZEDATA-1:0] alu_result;
  logic                tx_done;
  logic [SIZEDATA-1:0] datoa;
  logic [SIZEDATA-1:0] datob;
  logic [SIZEOP-1:0]   opcode;
  logic [SIZEDATA-1:0] tx_data;
  logic                tx_start;
  logic                busy;
  logic                overrun;

  modport master (
    output rx_data, rx_done, alu_result, tx_done,
    input  datoa, datob, opcode, tx_data, tx_start, busy, overrun
  );

  modport slave (
    input  rx_data, rx_done, alu_result, tx_done,
    output datoa, datob, opcode, tx_data, tx_start, busy, overrun
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes, drives them to the ALU, captures the
// result one cycle later and hands it to the transmitter with a start/done handshake.
module alu_uart_sequencer #(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = 6
) (
  input logic              i_clk,
  input logic              i_rst_n,
  alu_uart_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StWaitTx
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic                w_load_a;
  logic                w_load_b;
  logic                w_load_op;
  logic                w_exec;
  logic                w_overrun;
  logic [SIZEDATA-1:0] r_datoa;
  logic [SIZEDATA-1:0] r_datob;
  logic [SIZEOP-1:0]   r_opcode;
  logic [SIZEDATA-1:0] r_tx_data;
  logic                r_tx_start;
  logic                r_overrun;

  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_exec       = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      StWaitA: begin
        if (bus.rx_done) begin
          w_load_a     = 1'b1;
          w_state_next = StWaitB;
        end
      end
      StWaitB: begin
        if (bus.rx_done) begin
          w_load_b     = 1'b1;
          w_state_next = StWaitOp;
        end
      end
      StWaitOp: begin
        if (bus.rx_done) begin
          w_load_op    = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_exec       = 1'b1;
        w_overrun    = bus.rx_done;
        w_state_next = StWaitTx;
      end
      StWaitTx: begin
        // A byte arriving alongside TX_DONE is still dropped.
        w_overrun = bus.rx_done;
        if (bus.tx_done) begin
          w_state_next = StWaitA;
        end
      end
      default: w_state_next = StWaitA;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StWaitA;
      r_datoa    <= '0;
      r_datob    <= '0;
      r_opcode   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_start <= w_exec;
      r_overrun  <= w_overrun;
      if (w_load_a)  r_datoa   <= bus.rx_data;
      if (w_load_b)  r_datob   <= bus.rx_data;
      if (w_load_op) r_opcode  <= bus.rx_data[SIZEOP-1:0];
      if (w_exec)    r_tx_data <= bus.alu_result;
    end
  end

  assign bus.datoa    = r_datoa;
  assign bus.datob    = r_datob;
  assign bus.opcode   = r_opcode;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.overrun  = r_overrun;
  assign bus.busy     = (r_state == StExec) || (r_state == StWaitTx);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a small behavioural ALU attached.
module tb_alu_uart_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_uart_sequencer_if #(.SIZEDATA(8), .SIZEOP(6)) u_if ();

  alu_uart_sequencer #(.SIZEDATA(8), .SIZEOP(6)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
  always_comb begin
    u_if.alu_result = 8'h00;
    case (u_if.opcode)
      6'h20: u_if.alu_result = u_if.datoa + u_if.datob;
      6'h22: u_if.alu_result = u_if.datoa - u_if.datob;
      6'h24: u_if.alu_result = u_if.datoa & u_if.datob;
      6'h25: u_if.alu_result = u_if.datoa | u_if.datob;
      6'h26: u_if.alu_result = u_if.datoa ^ u_if.datob;
      6'h27: u_if.alu_result = ~(u_if.datoa | u_if.datob);
      6'h03: u_if.alu_result = $unsigned($signed(u_if.datoa) >>> u_if.datob);
      6'h02: u_if.alu_result = u_if.datoa >> u_if.datob;
      default: u_if.alu_result = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; strobes one byte and returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    u_if.rx_data = b;
    u_if.rx_done = 1'b1;
    @(negedge clk);
    u_if.rx_done = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [5:0] exp_op,
                         input logic [7:0] exp_res);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check_eq({tag, " opcode"}, 32'(u_if.opcode), 32'(exp_op));
    check_eq({tag, " exec busy"}, 32'(u_if.busy), 32'd1);
    check_eq({tag, " exec no start"}, 32'(u_if.tx_start), 32'd0);
    @(negedge clk);
    check_eq({tag, " tx_start"}, 32'(u_if.tx_start), 32'd1);
    check_eq({tag, " tx_data"}, 32'(u_if.tx_data), 32'(exp_res));
    @(negedge clk);
    check_eq({tag, " start drop"}, 32'(u_if.tx_start), 32'd0);
    check_eq({tag, " busy wait"}, 32'(u_if.busy), 32'd1);
    u_if.tx_done = 1'b1;
    @(negedge clk);
    u_if.tx_done = 1'b0;
    check_eq({tag, " idle"}, 32'(u_if.busy), 32'd0);
    check_eq({tag, " tx_data hold"}, 32'(u_if.tx_data), 32'(exp_res));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    u_if.rx_data = 8'h00;
    u_if.rx_done = 1'b0;
    u_if.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst datoa", 32'(u_if.datoa), 32'd0);
    check_eq("rst tx_data", 32'(u_if.tx_data), 32'd0);
    check_eq("rst tx_start", 32'(u_if.tx_start), 32'd0);
    check_eq("rst busy", 32'(u_if.busy), 32'd0);
    check_eq("rst overrun", 32'(u_if.overrun), 32'd0);

    // Stray TX_DONE outside WAIT_TX must be ignored.
    u_if.tx_done = 1'b1;
    @(negedge clk);
    u_if.tx_done = 1'b0;
    check_eq("stray tx_done busy", 32'(u_if.busy), 32'd0);

    run_txn("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
    check_eq("add datoa", 32'(u_if.datoa), 32'h05);
    check_eq("add datob", 32'(u_if.datob), 32'h03);
    run_txn("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
    run_txn("sra", 8'h80, 8'h01, 8'h03, 6'h03, 8'hC0);
    run_txn("and", 8'hF0, 8'h3C, 8'hE4, 6'h24, 8'h30);

    // Overrun: byte during WAIT_TX is dropped.
    send_byte(8'h09);
    send_byte(8'h06);
    send_byte(8'h27);
    @(negedge clk);
    check_eq("nor tx_data", 32'(u_if.tx_data), 32'hF0);
    send_byte(8'hAA);
    check_eq("ovr pulse", 32'(u_if.overrun), 32'd1);
    check_eq("ovr datoa", 32'(u_if.datoa), 32'h09);
    check_eq("ovr busy", 32'(u_if.busy), 32'd1);
    @(negedge clk);
    check_eq("ovr one cycle", 32'(u_if.overrun), 32'd0);
    u_if.tx_done = 1'b1;
    @(negedge clk);
    u_if.tx_done = 1'b0;
    run_txn("or", 8'h01, 8'h02, 8'h25, 6'h25, 8'h03);
    check_eq("or datoa", 32'(u_if.datoa), 32'h01);

    // Reset mid-transaction clears everything asynchronously.
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("pre-rst datoa", 32'(u_if.datoa), 32'h11);
    check_eq("pre-rst datob", 32'(u_if.datob), 32'h22);
    rst_n = 1'b0;
    #1;
    check_eq("async rst datoa", 32'(u_if.datoa), 32'd0);
    check_eq("async rst datob", 32'(u_if.datob), 32'd0);
    check_eq("async rst opcode", 32'(u_if.opcode), 32'd0);
    check_eq("async rst tx_data", 32'(u_if.tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("xor", 8'h04, 8'h04, 8'h26, 6'h26, 8'h00);
    check_eq("xor datoa", 32'(u_if.datoa), 32'h04);

    // Back-to-back strobes, TX_DONE during the TX_START cycle.
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("srl opcode", 32'(u_if.opcode), 32'h02);
    @(negedge clk);
    check_eq("srl tx_start", 32'(u_if.tx_start), 32'd1);
    check_eq("srl tx_data", 32'(u_if.tx_data), 32'h03);
    u_if.tx_done = 1'b1;
    @(negedge clk);
    u_if.tx_done = 1'b0;
    check_eq("srl fast idle", 32'(u_if.busy), 32'd0);
    check_eq("srl start low", 32'(u_if.tx_start), 32'd0);

    // RX and TX done together in WAIT_TX: returns idle, byte dropped, overrun pulses.
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    @(negedge clk);
    u_if.rx_data = 8'h55;
    u_if.rx_done = 1'b1;
    u_if.tx_done = 1'b1;
    @(negedge clk);
    u_if.rx_done = 1'b0;
    u_if.tx_done = 1'b0;
    check_eq("both idle", 32'(u_if.busy), 32'd0);
    check_eq("both overrun", 32'(u_if.overrun), 32'd1);
    check_eq("both datoa", 32'(u_if.datoa), 32'h02);
    check_eq("both tx_data", 32'(u_if.tx_data), 32'h05);
    run_txn("after both", 8'h10, 8'h20, 8'h20, 6'h20, 8'h30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
